// File: rtl/sclk_burst_gen_if.sv
// Control and strobe bundle for sclk_burst_gen; SCLK_BURST_FREE_RUN_EN adds free_run.
// Latency: none, wires only.
// Backpressure: none; the consumer reacts to the strobes, en pauses the generator.
interface sclk_burst_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] ncyc;
  logic             cpol;
  logic             start;
  logic             abort;
`ifdef SCLK_BURST_FREE_RUN_EN
  logic             free_run;
`endif
  logic             sclk;
  logic             rise;
  logic             fall;
  logic             busy;
  logic             done;

  modport master (
`ifdef SCLK_BURST_FREE_RUN_EN
    output free_run,
`endif
    output en, div, ncyc, cpol, start, abort,
    input  sclk, rise, fall, busy, done
  );

  modport slave (
`ifdef SCLK_BURST_FREE_RUN_EN
    input  free_run,
`endif
    input  en, div, ncyc, cpol, start, abort,
    output sclk, rise, fall, busy, done
  );
endinterface

// File: rtl/sclk_burst_gen.sv
// Burst serial-clock generator: ncyc sclk cycles at half-period div+1; SCLK_BURST_FREE_RUN_EN adds free_run.
// Latency: all outputs registered; first toggle div+1 clk after the start edge.
// Backpressure: en low freezes divider, edge count and sclk; start while busy is dropped.
module sclk_burst_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  sclk_burst_gen_if.slave bus
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] ncyc;
    logic             cpol;
  } cfg_t;

  state_t           state_q, state_n;
  cfg_t             cfg_q, cfg_n;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_n;
  logic [CNT_W:0]   edge_cnt_q, edge_cnt_n;
  logic             sclk_q, sclk_n;
  logic             rise_q, rise_n;
  logic             fall_q, fall_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  logic             at_div;
  logic [CNT_W:0]   edge_inc;
  logic             last_edge;
  logic             fr_live;
  logic             fr_sticky;
  logic             end_burst;

`ifdef SCLK_BURST_FREE_RUN_EN
  logic fr_q, fr_n;
  assign fr_live   = bus.free_run;
  assign fr_sticky = fr_q;
`else
  assign fr_live   = 1'b0;
  assign fr_sticky = 1'b0;
`endif

  assign at_div    = (div_cnt_q == cfg_q.div);
  assign edge_inc  = edge_cnt_q + 1'b1;
  assign last_edge = (edge_inc == {cfg_q.ncyc, 1'b0});

  // Once free-running, a burst ends only on a toggle that lands back on the idle level.
  always_comb begin
    if (fr_live)
      end_burst = 1'b0;
    else if (fr_sticky)
      end_burst = (sclk_q != cfg_q.cpol);
    else
      end_burst = last_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCLK_BURST_FREE_RUN_EN
      fr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      cfg_q      <= cfg_n;
      div_cnt_q  <= div_cnt_n;
      edge_cnt_q <= edge_cnt_n;
      sclk_q     <= sclk_n;
      rise_q     <= rise_n;
      fall_q     <= fall_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
`ifdef SCLK_BURST_FREE_RUN_EN
      fr_q       <= fr_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_q;
    cfg_n      = cfg_q;
    div_cnt_n  = div_cnt_q;
    edge_cnt_n = edge_cnt_q;
    sclk_n     = sclk_q;
    busy_n     = busy_q;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    done_n     = 1'b0;
`ifdef SCLK_BURST_FREE_RUN_EN
    fr_n       = fr_q;
`endif

    case (state_q)
      IDLE: begin
        sclk_n = bus.cpol;
        if (bus.start && !bus.abort) begin
          cfg_n      = '{div: bus.div, ncyc: bus.ncyc, cpol: bus.cpol};
          div_cnt_n  = '0;
          edge_cnt_n = '0;
`ifdef SCLK_BURST_FREE_RUN_EN
          fr_n       = bus.free_run;
`endif
          if (bus.ncyc == '0 && !fr_live) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
            busy_n  = 1'b1;
          end
        end
      end

      RUN: begin
`ifdef SCLK_BURST_FREE_RUN_EN
        fr_n = fr_q | bus.free_run;
`endif
        // Abort beats a coincident toggle and never raises a strobe.
        if (bus.abort) begin
          state_n = IDLE;
          sclk_n  = cfg_q.cpol;
          busy_n  = 1'b0;
        end else if (bus.en) begin
          if (at_div) begin
            sclk_n     = ~sclk_q;
            div_cnt_n  = '0;
            edge_cnt_n = (fr_live || fr_sticky) ? edge_cnt_q : edge_inc;
            rise_n     = ~sclk_q;
            fall_n     = sclk_q;
            if (end_burst) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            div_cnt_n = div_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.sclk = sclk_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_sclk_burst_gen.sv
// Directed bench for sclk_burst_gen; expected {sclk,rise,fall,busy,done} per edge are hand-computed.
module tb_sclk_burst_gen;
  localparam int DIV_W = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sclk_burst_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  sclk_burst_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp packs {sclk, rise, fall, busy, done}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.sclk, bus.rise, bus.fall, bus.busy, bus.done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] exp);
    tick();
    chk(tag, exp);
  endtask

  task automatic hold(input string tag, input int n, input logic [4:0] exp);
    for (int i = 0; i < n; i++) step(tag, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.div   = '0;
    bus.ncyc  = '0;
    bus.cpol  = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef SCLK_BURST_FREE_RUN_EN
    bus.free_run = 1'b0;
`endif

    // reset state, and reset overrides idle cpol tracking
    #2;
    chk("rst_state", 5'b00000);
    tick();
    tick();
    chk("rst_hold", 5'b00000);
    bus.cpol = 1'b0;
    rst_n    = 1'b1;
    step("idle_cpol0", 5'b00000);
    bus.cpol = 1'b1;
    step("idle_cpol1", 5'b10000);
    bus.cpol = 1'b0;
    step("idle_back0", 5'b00000);

    // div=0 ncyc=2 cpol=0
    bus.div = 8'd0; bus.ncyc = 8'd2; bus.start = 1'b1;
    step("a_e0", 5'b00010);
    bus.start = 1'b0;
    step("a_e1", 5'b11010);
    step("a_e2", 5'b00110);
    step("a_e3", 5'b11010);
    step("a_e4", 5'b00101);
    step("a_e5", 5'b00000);

    // div=3 ncyc=1 cpol=1
    bus.cpol = 1'b1;
    step("b_idle", 5'b10000);
    bus.div = 8'd3; bus.ncyc = 8'd1; bus.start = 1'b1;
    step("b_e0", 5'b10010);
    bus.start = 1'b0;
    hold("b_e1_3", 3, 5'b10010);
    step("b_e4", 5'b00110);
    hold("b_e5_7", 3, 5'b00010);
    step("b_e8", 5'b11001);
    step("b_e9", 5'b10000);

    // en pause: div=1 ncyc=2, en low for three edges after E2
    bus.cpol = 1'b0;
    step("c_idle", 5'b00000);
    bus.div = 8'd1; bus.ncyc = 8'd2; bus.start = 1'b1;
    step("c_e0", 5'b00010);
    bus.start = 1'b0;
    step("c_e1", 5'b00010);
    step("c_e2", 5'b11010);
    bus.en = 1'b0;
    hold("c_paused", 3, 5'b10010);
    bus.en = 1'b1;
    step("c_e6", 5'b10010);
    step("c_e7", 5'b00110);
    step("c_e8", 5'b00010);
    step("c_e9", 5'b11010);
    step("c_e10", 5'b10010);
    step("c_e11", 5'b00101);

    // abort at E6 of a div=0 ncyc=4 cpol=1 burst; config changes and start while busy ignored
    bus.div = 8'd0; bus.ncyc = 8'd4; bus.cpol = 1'b1;
    step("d_idle", 5'b10000);
    bus.start = 1'b1;
    step("d_e0", 5'b10010);
    bus.start = 1'b0; bus.cpol = 1'b0; bus.div = 8'd5;
    step("d_e1", 5'b00110);
    step("d_e2", 5'b11010);
    bus.start = 1'b1; bus.ncyc = 8'd0;
    step("d_e3", 5'b00110);
    step("d_e4", 5'b11010);
    bus.start = 1'b0;
    step("d_e5", 5'b00110);
    bus.abort = 1'b1;
    step("d_abort", 5'b10000);
    bus.abort = 1'b0;
    step("d_e7", 5'b00000);
    hold("d_no_done", 3, 5'b00000);

    // start and abort together in IDLE: abort wins
    bus.div = 8'd0; bus.ncyc = 8'd2; bus.start = 1'b1; bus.abort = 1'b1;
    step("idle_abort", 5'b00000);
    bus.start = 1'b0; bus.abort = 1'b0;
    step("idle_abort2", 5'b00000);

    // ncyc=0: immediate done, no busy, no edge
    bus.ncyc = 8'd0; bus.start = 1'b1;
    step("z_e0", 5'b00001);
    bus.start = 1'b0;
    hold("z_after", 2, 5'b00000);

    // back-to-back with start held through done
    bus.div = 8'd1; bus.ncyc = 8'd1; bus.start = 1'b1;
    step("bb_e0", 5'b00010);
    step("bb_e1", 5'b00010);
    step("bb_e2", 5'b11010);
    step("bb_e3", 5'b10010);
    step("bb_e4", 5'b00101);
    step("bb_e5", 5'b00010);
    bus.start = 1'b0;
    step("bb_e6", 5'b00010);
    step("bb_e7", 5'b11010);
    step("bb_e8", 5'b10010);
    step("bb_e9", 5'b00101);
    step("bb_e10", 5'b00000);

    // asynchronous reset mid-burst
    bus.div = 8'd3; bus.ncyc = 8'd2; bus.start = 1'b1;
    step("r_e0", 5'b00010);
    bus.start = 1'b0;
    hold("r_e1_3", 3, 5'b00010);
    step("r_e4", 5'b11010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 5'b00000);
    tick();
    chk("rst_async_hold", 5'b00000);
    rst_n = 1'b1;
    hold("rst_release", 6, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
